// File: rtl/ddr_traffic_checker.sv
// ddr_traffic_checker: writes a pattern over an address window, reads it back and counts mismatching beats.
module ddr_traffic_checker #(
  parameter int          DATA_WIDTH = 256,
  parameter int          ADDR_WIDTH = 28,
  parameter int          BURST_LEN  = 16,
  parameter int          ADDR_STEP  = 128,
  parameter int          START_ADDR = 0,
  parameter int          END_ADDR   = 4095,
  parameter logic [31:0] PRBS_SEED  = 32'h1234_5678
) (
  input  logic                  core_clk,
  input  logic                  ddr_rstn,
  input  logic                  ddr_init_done,
  input  logic                  test_start,
  input  logic [1:0]            test_mode,
  input  logic                  loop_en,
  output logic                  wr_cmd_valid,
  input  logic                  wr_cmd_ready,
  output logic [ADDR_WIDTH-1:0] wr_cmd_addr,
  output logic [7:0]            wr_cmd_len,
  output logic                  wr_data_valid,
  input  logic                  wr_data_ready,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_data_last,
  output logic                  rd_cmd_valid,
  input  logic                  rd_cmd_ready,
  output logic [ADDR_WIDTH-1:0] rd_cmd_addr,
  output logic [7:0]            rd_cmd_len,
  input  logic                  rd_data_valid,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_data_last,
  output logic                  test_busy,
  output logic                  test_done,
  output logic                  err_flag,
  output logic [15:0]           err_cnt,
  output logic [15:0]           pass_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);
  localparam int LANES = DATA_WIDTH / 32;
  localparam int LAST_ADDR = START_ADDR + ((END_ADDR - START_ADDR) / ADDR_STEP) * ADDR_STEP;
  localparam logic [7:0] LEN = 8'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] START = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(ADDR_STEP);

  typedef enum logic [2:0] {IDLE, WR_CMD, WR_DATA, RD_CMD, RD_DATA, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, cmp_addr_q, first_err_q;
  logic [7:0]            cnt_q;
  logic [31:0]           beat_q;
  logic [1:0]            mode_q;
  logic [30:0]           lfsr_q [LANES];
  logic [30:0]           lfsr_nxt [LANES];
  logic [31:0]           base_w [LANES];
  logic [62:0]           prbs_w [LANES];
  logic [DATA_WIDTH-1:0] pat, cmp_data_q, cmp_exp_q;
  logic                  abort_q, abort, cmp_v_q, cmp_last_q, err_flag_q;
  logic [15:0]           err_cnt_q, pass_cnt_q;
  logic                  last_beat, last_burst, wr_beat, rd_beat, start, new_pass, to_read, reseed, mismatch;

  // 32 steps of x^31+x^28+1; returns {32 generated bits, advanced state}
  function automatic logic [62:0] prbs32(input logic [30:0] s);
    logic [31:0] w;
    logic        b;
    w = '0;
    for (int k = 0; k < 32; k++) begin
      b = s[30] ^ s[27];
      s = {s[29:0], b};
      w = {w[30:0], b};
    end
    return {w, s};
  endfunction

  assign last_beat  = cnt_q == LEN;
  assign last_burst = addr_q == ADDR_WIDTH'(LAST_ADDR);
  assign wr_beat    = state_q == WR_DATA && wr_data_ready;
  assign rd_beat    = state_q == RD_DATA && rd_data_valid;
  assign start      = state_q == IDLE && ddr_init_done && test_start;
  assign new_pass   = start || (state_q == DONE && state_d == WR_CMD);
  assign to_read    = wr_beat && last_beat && last_burst;
  assign reseed     = new_pass || to_read;
  assign abort      = abort_q || !ddr_init_done;
  assign mismatch   = cmp_v_q && (cmp_last_q || cmp_data_q != cmp_exp_q);

  always_comb begin
    pat = '0;
    for (int i = 0; i < LANES; i++) begin
      prbs_w[i]   = prbs32(lfsr_q[i]);
      lfsr_nxt[i] = prbs_w[i][30:0];
      base_w[i]   = 32'(addr_q) + beat_q * LANES + 32'(i);
      pat[32*i +: 32] = mode_q == 2'd0 ? base_w[i] :
                        mode_q == 2'd1 ? 32'd1 << 5'(beat_q + 32'(i)) :
                        mode_q == 2'd2 ? prbs_w[i][62:31] : ~base_w[i];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start ? WR_CMD : IDLE;
      WR_CMD:  state_d = wr_cmd_ready ? WR_DATA : WR_CMD;
      WR_DATA: if (wr_beat && last_beat) state_d = abort ? IDLE : last_burst ? RD_CMD : WR_CMD;
      RD_CMD:  state_d = rd_cmd_ready ? RD_DATA : RD_CMD;
      RD_DATA: if (rd_beat && last_beat) state_d = abort ? IDLE : last_burst ? DONE : RD_CMD;
      DONE:    state_d = loop_en && test_start && ddr_init_done ? WR_CMD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (!ddr_rstn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      beat_q      <= '0;
      mode_q      <= '0;
      abort_q     <= 1'b0;
      cmp_v_q     <= 1'b0;
      cmp_last_q  <= 1'b0;
      cmp_data_q  <= '0;
      cmp_exp_q   <= '0;
      cmp_addr_q  <= '0;
      err_flag_q  <= 1'b0;
      err_cnt_q   <= '0;
      pass_cnt_q  <= '0;
      first_err_q <= '0;
      for (int i = 0; i < LANES; i++) lfsr_q[i] <= 31'(PRBS_SEED ^ 32'(i));
    end else begin
      state_q <= state_d;
      abort_q <= state_d != IDLE && abort;
      if (new_pass) begin
        addr_q <= START;
        cnt_q  <= '0;
        beat_q <= '0;
        mode_q <= test_mode;
      end else if (wr_beat || rd_beat) begin
        cnt_q  <= last_beat ? '0 : cnt_q + 8'd1;
        beat_q <= to_read ? '0 : beat_q + 32'd1;
        if (last_beat) addr_q <= to_read ? START : last_burst ? addr_q : addr_q + STEP;
      end
      for (int i = 0; i < LANES; i++)
        lfsr_q[i] <= reseed ? 31'(PRBS_SEED ^ 32'(i)) : (wr_beat || rd_beat) ? lfsr_nxt[i] : lfsr_q[i];
      // compare one cycle after the beat arrives
      cmp_v_q <= rd_beat;
      if (rd_beat) begin
        cmp_data_q <= rd_data;
        cmp_exp_q  <= pat;
        cmp_last_q <= rd_data_last != last_beat;
        cmp_addr_q <= addr_q;
      end
      if (start) begin
        err_flag_q  <= 1'b0;
        err_cnt_q   <= '0;
        first_err_q <= '0;
      end else if (mismatch) begin
        err_flag_q <= 1'b1;
        if (!err_flag_q) first_err_q <= cmp_addr_q;
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end
      if (state_q == DONE) pass_cnt_q <= pass_cnt_q + 16'd1;
    end
  end

  assign wr_cmd_valid   = state_q == WR_CMD;
  assign wr_cmd_addr    = wr_cmd_valid ? addr_q : '0;
  assign wr_cmd_len     = wr_cmd_valid ? LEN : '0;
  assign wr_data_valid  = state_q == WR_DATA;
  assign wr_data        = wr_data_valid ? pat : '0;
  assign wr_data_last   = wr_data_valid && last_beat;
  assign rd_cmd_valid   = state_q == RD_CMD;
  assign rd_cmd_addr    = rd_cmd_valid ? addr_q : '0;
  assign rd_cmd_len     = rd_cmd_valid ? LEN : '0;
  assign test_busy      = state_q != IDLE;
  assign test_done      = state_q == DONE;
  assign err_flag       = err_flag_q;
  assign err_cnt        = err_cnt_q;
  assign pass_cnt       = pass_cnt_q;
  assign first_err_addr = first_err_q;
endmodule

// File: doc/ddr_traffic_checker.md
Name: ddr_traffic_checker

Overview:
- Parametrised DDR3 traffic generator and read-back checker. It is the successor to the fixed write/read self-test inside test_ddr.
- Sits between the board-level test control and the DDR controller user port. It writes a programmable pattern over an address window, reads the window back and compares every beat.
- Adds selectable data patterns, configurable window, burst length and data width, loop mode, error counting and first-failing-address capture.

Parameters:
- DATA_WIDTH, 256, user data bus width; multiple of 32 (MEM_DQ_WIDTH x 8 beats).
- ADDR_WIDTH, 28, controller command address width.
- BURST_LEN, 16, beats per command, 1..256.
- ADDR_STEP, 128, address increment per command.
- START_ADDR, 0, first burst address of the window.
- END_ADDR, 4095, window limit; last burst is the largest START_ADDR + k*ADDR_STEP <= END_ADDR.
- PRBS_SEED, 32'h1234_5678, LFSR seed for lane 0; lane i seed is PRBS_SEED ^ i.

Ports:
- core_clk  in  1  user-port clock; the only clock.
- ddr_rstn  in  1  synchronous, active-low reset.
- ddr_init_done  in  1  controller calibration complete.
- test_start  in  1  level; sampled only in IDLE.
- test_mode  in  2  0 = address, 1 = walking-one, 2 = PRBS31, 3 = inverted address.
- loop_en  in  1  rerun passes until test_start drops.
- wr_cmd_valid  out  1 / wr_cmd_ready  in  1 / wr_cmd_addr  out  ADDR_WIDTH / wr_cmd_len  out  8  write command, len = BURST_LEN-1.
- wr_data_valid  out  1 / wr_data_ready  in  1 / wr_data  out  DATA_WIDTH / wr_data_last  out  1  write data.
- rd_cmd_valid  out  1 / rd_cmd_ready  in  1 / rd_cmd_addr  out  ADDR_WIDTH / rd_cmd_len  out  8  read command.
- rd_data_valid  in  1 / rd_data  in  DATA_WIDTH / rd_data_last  in  1  read data; no backpressure.
- test_busy  out  1  pass in progress.
- test_done  out  1  one-cycle pulse at end of each completed pass.
- err_flag  out  1  sticky; clears only on a new start from IDLE.
- err_cnt  out  16  mismatching beats, saturates at 16'hFFFF.
- pass_cnt  out  16  completed passes, wraps.
- first_err_addr  out  ADDR_WIDTH  burst address of the first mismatch.

Behaviour:
- Reset values (ddr_rstn low at a core_clk edge): all outputs 0, FSM in IDLE, LFSRs at their seeds. A reset mid-burst drops all valids on that edge.
- FSM states and transitions:
  - IDLE -> WR_CMD when ddr_init_done & test_start. On this transition clear err_flag, err_cnt and first_err_addr, and set addr = START_ADDR.
  - WR_CMD: hold wr_cmd_valid high with stable addr/len until wr_cmd_ready. Then -> WR_DATA.
  - WR_DATA: issue BURST_LEN beats, one per wr_data_ready cycle. wr_data_last is high on beat BURST_LEN-1. After the last beat: if more bursts remain, addr += ADDR_STEP and -> WR_CMD; otherwise addr = START_ADDR, reseed the generator, -> RD_CMD.
  - RD_CMD: hold rd_cmd_valid until rd_cmd_ready, then -> RD_DATA. Only one burst is outstanding.
  - RD_DATA: compare each rd_data_valid beat against the regenerated expected pattern, registered with 1-cycle latency. After BURST_LEN beats: next burst -> RD_CMD, or window end -> DONE.
  - DONE: pulse test_done, increment pass_cnt. If loop_en & test_start -> WR_CMD (keep error state, reseed); else -> IDLE.
- Valid/payload stay stable while valid is high and ready is low. Write data never precedes acceptance of its command.
- Pattern generation, per 32-bit lane i, beat index b counted from the start of the pass:
  - Mode 0: lane = burst_addr + b*DATA_WIDTH/32 + i.
  - Mode 1: lane = 1 << ((b + i) mod 32).
  - Mode 2: lane = 32-bit PRBS31 word (x^31+x^28+1), advanced 32 steps per beat.
  - Mode 3: ~mode 0.
  - test_mode is latched at pass start; changes mid-pass are ignored.
- Mismatch handling: on the first mismatch of a run, capture first_err_addr and set err_flag. Each mismatching beat increments err_cnt.
- rd_data_last mismatch: rd_data_last not on beat BURST_LEN-1, or missing on that beat, counts as one error.
- ddr_init_done falling while busy: finish the current burst handshake, then -> IDLE. No test_done pulse and no pass_cnt increment.
- Window holding exactly one burst (START_ADDR + ADDR_STEP > END_ADDR): one write burst and one read burst.
- test_busy is high in every state except IDLE.

Test Plan:
- Mode 0, BURST_LEN=4, window 0..383, ideal memory model -> 3 write and 3 read bursts at addr 0/128/256; test_done pulses once; pass_cnt=1; err_cnt=0.
- Mode 2, corrupt bit 5 of read beat 2 of burst at addr 128 -> err_flag=1, err_cnt=1, first_err_addr=128.
- wr_data_ready held low for 10 cycles mid-burst -> wr_data and wr_data_last stable throughout; no beat lost; pass still clean.
- loop_en=1 for 3 passes with a persistent single-bit error -> pass_cnt=3, err_cnt=3, first_err_addr unchanged.
- Assert ddr_rstn low during WR_DATA -> next edge all valids 0; err_cnt=0, pass_cnt=0; a restart completes cleanly.
- Force rd_data_last on beat 1 of 4 -> err_cnt increments by exactly 1 for that burst.
